// File: rtl/fga_pkg.sv
// Shared register map, control bit positions and state/mode encodings for the screen write path.
// No logic; constants and types only.
// Imported by screen_write_engine and its testbench.
package fga_pkg;

    localparam logic [3:0] REG_MODE     = 4'd0;
    localparam logic [3:0] REG_DATA     = 4'd1;
    localparam logic [3:0] REG_STEP     = 4'd2;
    localparam logic [3:0] REG_ADDR_LO  = 4'd3;
    localparam logic [3:0] REG_ADDR_HI  = 4'd4;
    localparam logic [3:0] REG_FILL_VAL = 4'd5;
    localparam logic [3:0] REG_COUNT_LO = 4'd6;
    localparam logic [3:0] REG_COUNT_HI = 4'd7;
    localparam logic [3:0] REG_CTRL     = 4'd8;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_CLRERR_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_MONO_TEXT   = 2'd0,
        MODE_COLOUR_TEXT = 2'd1,
        MODE_MONO_BMP    = 2'd2,
        MODE_HI_BMP      = 2'd3
    } mode_t;

endpackage

// File: rtl/fga_sync_fifo.sv
// Single-clock FIFO of 2**AW words; head word is read straight from the storage flops.
// Latency: a word pushed at edge k is visible on rd_dat and poppable at edge k+1.
// Backpressure: push ignored when full, pop ignored when empty; caller owns any drop policy.
module fga_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/screen_write_engine.sv
// Host register front end driving the screen RAM write port: cursor-addressed DATA queue plus hardware fill.
// Latency: DATA strobe sampled at edge n reaches ram_* at edge n+1 when idle; fill writes one cell per cycle.
// Backpressure: none towards the host; pushes into a full queue or config writes while busy are dropped and flag err.
module screen_write_engine
    import fga_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int FIFO_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_we,
    input  logic [3:0]        reg_sel,
    input  logic [7:0]        reg_wdata,
    output logic [1:0]        mode,
    output logic              busy,
    output logic              fifo_full,
    output logic              err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data
);

    state_t            state_q, state_nxt;
    mode_t             mode_q;
    logic [7:0]        step_q, fill_val_q;
    logic [15:0]       count_q, rem_q, rem_nxt;
    logic [ADDR_W-1:0] cursor_q, cursor_nxt, cur_mid, step_ext;
    logic [15:0]       cur16;
    logic              err_q, err_nxt;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_data_q;

    logic              push_req, push_ok, push_drop;
    logic              cfg_wr, cfg_ok, cfg_drop, ctrl_wr;
    logic              pop, fill_w;
    logic              fifo_full_w, fifo_empty;
    logic [ADDR_W+7:0] fifo_wr_dat, fifo_rd_dat;

    assign busy      = (state_q != ST_IDLE);
    assign fifo_full = fifo_full_w;
    assign err       = err_q;
    assign mode      = mode_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;

    assign step_ext  = ADDR_W'(step_q);
    assign cur16     = 16'(cursor_q);
    assign push_req  = reg_we && (reg_sel == REG_DATA);
    assign push_ok   = push_req && !fifo_full_w;
    assign push_drop = push_req && fifo_full_w;
    assign cfg_wr    = reg_we && (reg_sel >= REG_STEP) && (reg_sel <= REG_COUNT_HI);
    assign cfg_ok    = cfg_wr && !busy;
    assign cfg_drop  = cfg_wr && busy;
    assign ctrl_wr   = reg_we && (reg_sel == REG_CTRL);

    // FLUSH issues the first fill write in the cycle it finds the queue empty,
    // so a fill of COUNT cells keeps busy high for exactly COUNT cycles after start.
    always_comb begin
        state_nxt = state_q;
        rem_nxt   = rem_q;
        pop       = 1'b0;
        fill_w    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pop = !fifo_empty;
                if (ctrl_wr && reg_wdata[CTRL_START_BIT] && (count_q != 16'd0)) begin
                    state_nxt = ST_FLUSH;
                    rem_nxt   = count_q;
                end
            end
            ST_FLUSH: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end else begin
                    fill_w    = 1'b1;
                    rem_nxt   = rem_q - 16'd1;
                    state_nxt = (rem_q == 16'd1) ? ST_IDLE : ST_FILL;
                end
            end
            ST_FILL: begin
                fill_w  = 1'b1;
                rem_nxt = rem_q - 16'd1;
                if (rem_q == 16'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A push coinciding with a fill write takes the cursor after the fill step, so they never share a cell.
    always_comb begin
        cur_mid     = fill_w ? (cursor_q + step_ext) : cursor_q;
        fifo_wr_dat = {cur_mid, reg_wdata};
        cursor_nxt  = cur_mid;
        if (push_ok) cursor_nxt = cur_mid + step_ext;
        if (cfg_ok && (reg_sel == REG_ADDR_LO)) cursor_nxt = ADDR_W'({cur16[15:8], reg_wdata});
        if (cfg_ok && (reg_sel == REG_ADDR_HI)) cursor_nxt = ADDR_W'({reg_wdata, cur16[7:0]});
    end

    always_comb begin
        err_nxt = err_q;
        if (ctrl_wr && reg_wdata[CTRL_CLRERR_BIT]) err_nxt = 1'b0;
        if (push_drop || cfg_drop) err_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_MONO_TEXT;
            step_q     <= 8'd1;
            fill_val_q <= 8'd0;
            count_q    <= 16'd0;
            rem_q      <= 16'd0;
            cursor_q   <= '0;
            err_q      <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= 8'd0;
        end else begin
            state_q  <= state_nxt;
            rem_q    <= rem_nxt;
            cursor_q <= cursor_nxt;
            err_q    <= err_nxt;
            if (reg_we && (reg_sel == REG_MODE)) mode_q <= mode_t'(reg_wdata[1:0]);
            if (cfg_ok && (reg_sel == REG_STEP)) step_q <= reg_wdata;
            if (cfg_ok && (reg_sel == REG_FILL_VAL)) fill_val_q <= reg_wdata;
            if (cfg_ok && (reg_sel == REG_COUNT_LO)) count_q[7:0] <= reg_wdata;
            if (cfg_ok && (reg_sel == REG_COUNT_HI)) count_q[15:8] <= reg_wdata;
            if (pop) begin
                ram_we_q                 <= 1'b1;
                {ram_addr_q, ram_data_q} <= fifo_rd_dat;
            end else if (fill_w) begin
                ram_we_q   <= 1'b1;
                ram_addr_q <= cursor_q;
                ram_data_q <= fill_val_q;
            end else begin
                ram_we_q <= 1'b0;
            end
        end
    end

    fga_sync_fifo #(
        .WIDTH (ADDR_W + 8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (push_ok),
        .wr_dat (fifo_wr_dat),
        .rd_rdy (pop),
        .rd_dat (fifo_rd_dat),
        .full   (fifo_full_w),
        .empty  (fifo_empty)
    );

endmodule
